locking_rr_queue_arbiter: RTL and testbench

Shares one queue enqueue port among N decoupled requesters using round-robin arbitration. Once a requester wins, the grant is held for a fixed burst of BEATS transfers, so each burst lands contiguously in the downstream queue. The block sits between N producers and the enq side of a shared queue. Arbitration is combinational, with zero added latency; sequential state holds only the round-robin pointer and the burst lock.

---
 rtl/locking_rr_queue_arbiter.sv | 91 +++++++++
 tb/tb_locking_rr_queue_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/locking_rr_queue_arbiter.sv
// locking_rr_queue_arbiter: round-robin arbiter onto one queue enq port.
// The winner keeps the grant for a burst of BEATS transfers.
// Optional RR_ARB_STATS_EN adds grant and burst counters.
module locking_rr_queue_arbiter #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int BEATS = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_bits,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_bits,
    output logic [IW-1:0]  out_chosen,
    output logic           locked
`ifdef RR_ARB_STATS_EN
    ,
    output logic [15:0]    grant_count,
    output logic [15:0]    burst_count
`endif
);
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [IW-1:0] last_grant, lock_idx, scan_idx, chosen;
    logic [BW-1:0] beat_cnt;
    logic          found, fire, last_beat;

    // first valid requester after last_grant, or last_grant+1 when none is valid
    always_comb begin
        scan_idx = IW'((int'(last_grant) + 1) % N);
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && in_valid[(int'(last_grant) + k) % N]) begin
                scan_idx = IW'((int'(last_grant) + k) % N);
                found = 1'b1;
            end
        end
    end

    assign chosen     = locked ? lock_idx : scan_idx;
    assign out_chosen = chosen;
    assign out_valid  = in_valid[chosen];
    assign out_bits   = in_bits[int'(chosen)*W +: W];
    assign in_ready   = out_ready ? (N'(1) << chosen) : '0;
    assign fire       = out_valid && out_ready;
    assign last_beat  = locked && (beat_cnt == BW'(BEATS - 1));

    // round-robin pointer and burst lock advance only on a transferred beat
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IW'(N - 1);
            locked     <= 1'b0;
            lock_idx   <= '0;
            beat_cnt   <= '0;
        end else if (fire) begin
            last_grant <= chosen;
            if (!locked) begin
                if (BEATS > 1) begin
                    locked   <= 1'b1;
                    lock_idx <= chosen;
                    beat_cnt <= BW'(1);
                end
            end else if (last_beat) begin
                locked   <= 1'b0;
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + BW'(1);
            end
        end
    end

`ifdef RR_ARB_STATS_EN
    logic burst_done;
    assign burst_done = fire && (BEATS == 1 || last_beat);

    // wrapping counts of transferred beats and completed bursts
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count <= '0;
            burst_count <= '0;
        end else begin
            if (fire) grant_count <= grant_count + 16'd1;
            if (burst_done) burst_count <= burst_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_locking_rr_queue_arbiter.sv
// tb_locking_rr_queue_arbiter: directed vector bench for the locking round-robin arbiter.
module tb_locking_rr_queue_arbiter;
    logic        clk = 1'b0;
    logic        reset_a, out_ready_a, out_valid_a, locked_a;
    logic [3:0]  in_valid_a, in_ready_a;
    logic [7:0]  out_bits_a;
    logic [1:0]  chosen_a;
    logic        reset_b, out_ready_b, out_valid_b, locked_b;
    logic [3:0]  in_valid_b, in_ready_b;
    logic [7:0]  out_bits_b;
    logic [1:0]  chosen_b;
    logic [31:0] in_bits = 32'hA3A2A1A0;
`ifdef RR_ARB_STATS_EN
    logic [15:0] gc_a, bc_a, gc_b, bc_b;
`endif
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    locking_rr_queue_arbiter #(.N(4), .W(8), .BEATS(4)) u_lock (
        .clk(clk), .reset(reset_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_bits(in_bits), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_bits(out_bits_a), .out_chosen(chosen_a), .locked(locked_a)
`ifdef RR_ARB_STATS_EN
        , .grant_count(gc_a), .burst_count(bc_a)
`endif
    );

    locking_rr_queue_arbiter #(.N(4), .W(8), .BEATS(1)) u_rr (
        .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_bits(in_bits), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_bits(out_bits_b), .out_chosen(chosen_b), .locked(locked_b)
`ifdef RR_ARB_STATS_EN
        , .grant_count(gc_b), .burst_count(bc_b)
`endif
    );

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       rdy;
        logic       chk;
        logic [1:0] ec;
        logic       el;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [3:0] v, input logic rdy,
                                input logic chk, input logic [1:0] ec, input logic el);
        vec_t t;
        t.rst = rst; t.v = v; t.rdy = rdy; t.chk = chk; t.ec = ec; t.el = el;
        vecs.push_back(t);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        reset_a = 1'b1; in_valid_a = '0; out_ready_a = 1'b0;
        reset_b = 1'b1; in_valid_b = '0; out_ready_b = 1'b0;
        add(1, 4'hF, 1, 0, 0, 0);
        add(0, 4'h0, 1, 1, 0, 0);
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 4; k++)
                add(0, 4'hF, 1, 1, 2'(b), k != 0);
        add(0, 4'hF, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 4'hF, 1, 1, 0, 1);
        add(0, 4'b0100, 1, 1, 2, 0);
        for (int k = 0; k < 5; k++) add(0, 4'b0001, 1, 1, 2, 1);
        for (int k = 0; k < 3; k++) add(0, 4'b0101, 1, 1, 2, 1);
        add(0, 4'b0101, 1, 1, 0, 0);
        add(0, 4'hF, 1, 1, 0, 1);
        for (int k = 0; k < 3; k++) add(0, 4'hF, 0, 1, 0, 1);
        add(0, 4'hF, 1, 1, 0, 1);
        add(0, 4'hF, 1, 1, 0, 1);
        add(0, 4'hF, 1, 1, 1, 0);
        add(0, 4'hF, 1, 1, 1, 1);
        add(1, 4'hF, 1, 0, 0, 0);
        add(0, 4'hF, 1, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            logic       ev;
            logic [3:0] er;
            @(negedge clk);
            reset_a = vecs[i].rst; in_valid_a = vecs[i].v; out_ready_a = vecs[i].rdy;
            #1;
            if (vecs[i].chk) begin
                ev = vecs[i].v[vecs[i].ec];
                er = vecs[i].rdy ? 4'(1 << vecs[i].ec) : 4'h0;
                check($sformatf("v%0d chosen", i), 32'(chosen_a), 32'(vecs[i].ec));
                check($sformatf("v%0d out_valid", i), 32'(out_valid_a), 32'(ev));
                check($sformatf("v%0d in_ready", i), 32'(in_ready_a), 32'(er));
                check($sformatf("v%0d locked", i), 32'(locked_a), 32'(vecs[i].el));
                check($sformatf("v%0d out_bits", i), 32'(out_bits_a), 32'(8'hA0 + 8'(vecs[i].ec)));
            end
        end

        @(negedge clk);
        reset_b = 1'b0; in_valid_b = 4'b1010; out_ready_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr%0d chosen", k), 32'(chosen_b), (k % 2 == 0) ? 32'd1 : 32'd3);
            check($sformatf("rr%0d in_ready", k), 32'(in_ready_b), (k % 2 == 0) ? 32'h2 : 32'h8);
            check($sformatf("rr%0d locked", k), 32'(locked_b), 32'd0);
            @(negedge clk);
        end

`ifdef RR_ARB_STATS_EN
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0; in_valid_a = 4'hF; out_ready_a = 1'b1;
        repeat (12) @(negedge clk);
        out_ready_a = 1'b0;
        #1;
        check("grant_count 12", 32'(gc_a), 32'd12);
        check("burst_count 3", 32'(bc_a), 32'd3);
        out_ready_a = 1'b1;
        repeat (65536 - 12) @(negedge clk);
        out_ready_a = 1'b0;
        #1;
        check("grant_count wrap", 32'(gc_a), 32'd0);
        check("burst_count 16384", 32'(bc_a), 32'd16384);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
